sata_oob_controller: RTL and testbench
======================================

SATA_OOB_CONTROLLER -- requirements
Module: sata_oob_controller

Interface
REQ-001 Parameter TIMEOUT, default 32'd1_000_000: clk cycles before any wait state gives up and retries COMRESET.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (rst==0 resets).
REQ-004 platform_ready  in  1  transceiver/PLL ready.
REQ-005 linkup  out  1  OOB done, link established.
REQ-006 tx_dout  out  32  transmit dword.
REQ-007 tx_isk  out  1  tx_dout byte0 is K character.
REQ-008 tx_comm_reset  out  1  request COMRESET burst.
REQ-009 tx_comm_wake  out  1  request COMWAKE burst.
REQ-010 tx_set_elec_idle  out  1  force TX electrical idle.
REQ-011 rx_din  in  32  received dword.
REQ-012 rx_isk  in  4  per-byte K flags.
REQ-013 comm_init_detect  in  1  COMINIT detected.
REQ-014 comm_wake_detect  in  1  COMWAKE detected.
REQ-015 rx_byte_is_aligned  in  1  comma alignment valid.
REQ-016 rx_is_elec_idle  in  1  RX line idle.
REQ-017 lax_state  out  4  current state encoding (debug).

Function
REQ-018 Moore FSM, 4-bit state, lax_state = state: IDLE=0, SEND_RESET=1, WAIT_INIT=2, WAIT_NO_INIT=3, SEND_WAKE=4, WAIT_WAKE=5, WAIT_NO_WAKE=6, WAIT_ALIGN=7, SEND_ALIGN=8, READY=9.
REQ-019 IDLE -> SEND_RESET when platform_ready=1.
REQ-020 SEND_RESET lasts exactly 1 cycle, tx_comm_reset=1 only there; -> WAIT_INIT.
REQ-021 WAIT_INIT -> WAIT_NO_INIT on comm_init_detect=1.
REQ-022 WAIT_NO_INIT -> SEND_WAKE when comm_init_detect=0 and rx_is_elec_idle=1.
REQ-023 SEND_WAKE lasts 1 cycle, tx_comm_wake=1 only there; -> WAIT_WAKE.
REQ-024 WAIT_WAKE -> WAIT_NO_WAKE on comm_wake_detect=1.
REQ-025 WAIT_NO_WAKE -> WAIT_ALIGN when comm_wake_detect=0.
REQ-026 WAIT_ALIGN -> SEND_ALIGN when rx_din==32'h7B4A4ABC and rx_isk[0]=1 and rx_byte_is_aligned=1.
REQ-027 SEND_ALIGN counts consecutive non-ALIGN primitives (rx_isk[0]=1, rx_din!=ALIGN, rx_byte_is_aligned=1); ALIGN clears count; non-K words leave count unchanged; count==3 -> READY.
REQ-028 READY: linkup=1; comm_init_detect=1 -> SEND_RESET.
REQ-029 Timeout counter (32-bit) clears on each state entry, increments in WAIT_INIT, WAIT_WAKE, WAIT_NO_WAKE, WAIT_ALIGN, SEND_ALIGN; reaching TIMEOUT -> SEND_RESET; state's own exit condition wins on same cycle.
REQ-030 platform_ready=0 in any state -> IDLE next cycle, priority over all other transitions.
REQ-031 tx_set_elec_idle=1 in states 0-6, 0 in states 7-9.
REQ-032 tx_dout/tx_isk: states 0-6 32'h0/0; WAIT_ALIGN 32'h4A4A4A4A (D10.2 dial tone)/0; SEND_ALIGN, READY 32'h7B4A4ABC/1.
REQ-033 All outputs decoded combinationally from state register only.

Reset
REQ-034 rst=0 at clk edge: state=IDLE, timeout and primitive counters=0; hence linkup=0, tx_comm_reset=0, tx_comm_wake=0, tx_set_elec_idle=1, tx_dout=0, tx_isk=0, lax_state=0.
REQ-035 Reset mid-handshake (any state) aborts immediately; no burst request issued on the reset cycle.

Structure
REQ-036 PRIM_ALIGN (32'h7B4A4ABC), DIALTONE (32'h4A4A4A4A) and state encodings live in shared SATA defines package.
REQ-037 One sub-module natural: oob_timeout_counter (clear, enable, TIMEOUT compare, expired flag).

Verification (TIMEOUT overridden to 100)
REQ-038 Full bring-up: platform_ready=1, COMINIT pulse, COMWAKE pulse, ALIGNs, then 3 SYNC (32'hB5B5957C, isk=1) -> lax_state 1..9 in order, single-cycle comm_reset/comm_wake pulses, linkup=1.
REQ-039 No COMINIT: platform_ready=1 only -> tx_comm_reset pulses every ~102 cycles, linkup stays 0.
REQ-040 ALIGN interleaved: SYNC, SYNC, ALIGN, SYNC -> still SEND_ALIGN; three further SYNCs -> READY.
REQ-041 In READY assert comm_init_detect -> next state SEND_RESET, linkup=0, tx_comm_reset=1 one cycle.
REQ-042 rst=0 while in WAIT_ALIGN -> next cycle lax_state=0, tx_set_elec_idle=1, tx_dout=0.
REQ-043 platform_ready drops in SEND_ALIGN -> IDLE next cycle; reassertion restarts from SEND_RESET.

Source files
------------

// File: rtl/sata_oob_controller_pkg.sv
// Shared SATA definitions: primitive dwords and OOB state encodings.
package sata_oob_controller_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] DIALTONE   = 32'h4A4A4A4A;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_SEND_RESET   = 4'd1,
        ST_WAIT_INIT    = 4'd2,
        ST_WAIT_NO_INIT = 4'd3,
        ST_SEND_WAKE    = 4'd4,
        ST_WAIT_WAKE    = 4'd5,
        ST_WAIT_NO_WAKE = 4'd6,
        ST_WAIT_ALIGN   = 4'd7,
        ST_SEND_ALIGN   = 4'd8,
        ST_READY        = 4'd9
    } oob_state_e;

    // States in which a silent partner eventually forces a COMRESET retry.
    function automatic logic is_timed_state(input oob_state_e s);
        return (s == ST_WAIT_INIT)    || (s == ST_WAIT_WAKE)  ||
               (s == ST_WAIT_NO_WAKE) || (s == ST_WAIT_ALIGN) ||
               (s == ST_SEND_ALIGN);
    endfunction

endpackage

// File: rtl/oob_timeout_counter.sv
// Per-state wait timer: cleared on state entry, flags when TIMEOUT cycles have elapsed.
module oob_timeout_counter #(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    assign expired = (count_q >= TIMEOUT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sata_oob_controller.sv
// SATA host OOB handshake: COMRESET/COMINIT, COMWAKE, then ALIGN exchange up to link-up.
module sata_oob_controller
    import sata_oob_controller_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        platform_ready,
    output logic        linkup,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    output logic        tx_comm_reset,
    output logic        tx_comm_wake,
    output logic        tx_set_elec_idle,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_isk,
    input  logic        comm_init_detect,
    input  logic        comm_wake_detect,
    input  logic        rx_byte_is_aligned,
    input  logic        rx_is_elec_idle,
    output logic [3:0]  lax_state
);

    oob_state_e state_q;
    oob_state_e state_d;
    logic [1:0] prim_cnt_q;
    logic [1:0] prim_cnt_d;
    logic       timed_out;
    logic       rx_prim;
    logic       rx_align;
    logic       rx_isk_unused;

    // Primitives carry their K character in byte 0 only.
    assign rx_isk_unused = ^rx_isk[3:1];
    assign rx_prim       = rx_isk[0] && rx_byte_is_aligned;
    assign rx_align      = rx_prim && (rx_din == PRIM_ALIGN);

    oob_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .enable  (is_timed_state(state_q)),
        .expired (timed_out)
    );

    always_comb begin
        state_d    = state_q;
        prim_cnt_d = '0;
        case (state_q)
            ST_IDLE:         if (platform_ready) state_d = ST_SEND_RESET;
            ST_SEND_RESET:   state_d = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (comm_init_detect)  state_d = ST_WAIT_NO_INIT;
                else if (timed_out)    state_d = ST_SEND_RESET;
            end
            ST_WAIT_NO_INIT: if (!comm_init_detect && rx_is_elec_idle) state_d = ST_SEND_WAKE;
            ST_SEND_WAKE:    state_d = ST_WAIT_WAKE;
            ST_WAIT_WAKE: begin
                if (comm_wake_detect)  state_d = ST_WAIT_NO_WAKE;
                else if (timed_out)    state_d = ST_SEND_RESET;
            end
            ST_WAIT_NO_WAKE: begin
                if (!comm_wake_detect) state_d = ST_WAIT_ALIGN;
                else if (timed_out)    state_d = ST_SEND_RESET;
            end
            ST_WAIT_ALIGN: begin
                if (rx_align)          state_d = ST_SEND_ALIGN;
                else if (timed_out)    state_d = ST_SEND_RESET;
            end
            ST_SEND_ALIGN: begin
                // Link-up on the edge that accepts the third consecutive non-ALIGN primitive.
                prim_cnt_d = prim_cnt_q;
                if (rx_align)     prim_cnt_d = '0;
                else if (rx_prim) prim_cnt_d = prim_cnt_q + 2'd1;
                if (prim_cnt_d == 2'd3) state_d = ST_READY;
                else if (timed_out)     state_d = ST_SEND_RESET;
            end
            ST_READY:        if (comm_init_detect) state_d = ST_SEND_RESET;
            default:         state_d = ST_IDLE;
        endcase
        if (!platform_ready) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            prim_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prim_cnt_q <= prim_cnt_d;
        end
    end

    always_comb begin
        lax_state        = state_q;
        linkup           = (state_q == ST_READY);
        tx_comm_reset    = (state_q == ST_SEND_RESET);
        tx_comm_wake     = (state_q == ST_SEND_WAKE);
        tx_set_elec_idle = 1'b1;
        tx_dout          = '0;
        tx_isk           = 1'b0;
        case (state_q)
            ST_WAIT_ALIGN: begin
                tx_set_elec_idle = 1'b0;
                tx_dout          = DIALTONE;
            end
            ST_SEND_ALIGN, ST_READY: begin
                tx_set_elec_idle = 1'b0;
                tx_dout          = PRIM_ALIGN;
                tx_isk           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sata_oob_controller.sv
// Scoreboarded bench for the OOB controller with a short timeout.
module tb_sata_oob_controller;

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        platform_ready = 1'b0;
    logic        linkup;
    logic [31:0] tx_dout;
    logic        tx_isk;
    logic        tx_comm_reset;
    logic        tx_comm_wake;
    logic        tx_set_elec_idle;
    logic [31:0] rx_din = '0;
    logic [3:0]  rx_isk = '0;
    logic        comm_init_detect = 1'b0;
    logic        comm_wake_detect = 1'b0;
    logic        rx_byte_is_aligned = 1'b0;
    logic        rx_is_elec_idle = 1'b0;
    logic [3:0]  lax_state;

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];

    sata_oob_controller #(
        .TIMEOUT (32'd100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .platform_ready     (platform_ready),
        .linkup             (linkup),
        .tx_dout            (tx_dout),
        .tx_isk             (tx_isk),
        .tx_comm_reset      (tx_comm_reset),
        .tx_comm_wake       (tx_comm_wake),
        .tx_set_elec_idle   (tx_set_elec_idle),
        .rx_din             (rx_din),
        .rx_isk             (rx_isk),
        .comm_init_detect   (comm_init_detect),
        .comm_wake_detect   (comm_wake_detect),
        .rx_byte_is_aligned (rx_byte_is_aligned),
        .rx_is_elec_idle    (rx_is_elec_idle),
        .lax_state          (lax_state)
    );

    always #5 clk = ~clk;

    // {state, linkup, comm_reset, comm_wake, elec_idle, isk, dout} expected in a given state.
    function automatic logic [40:0] exp_out(input logic [3:0] s);
        logic [31:0] d;
        d = (s == 4'd7) ? 32'h4A4A4A4A : (s >= 4'd8) ? ALIGN : 32'h0;
        return {s, s == 4'd9, s == 4'd1, s == 4'd4, s < 4'd7, s >= 4'd8, d};
    endfunction

    task automatic cyc(input logic [3:0] s);
        exp_q.push_back(exp_out(s));
        @(posedge clk);
        #1;
        obs_q.push_back({lax_state, linkup, tx_comm_reset, tx_comm_wake,
                         tx_set_elec_idle, tx_isk, tx_dout});
    endtask

    task automatic clear_inputs;
        comm_init_detect   = 1'b0;
        comm_wake_detect   = 1'b0;
        rx_din             = '0;
        rx_isk             = '0;
        rx_byte_is_aligned = 1'b0;
        rx_is_elec_idle    = 1'b0;
    endtask

    task automatic goto_wait_align;
        rst = 1'b0; clear_inputs(); platform_ready = 1'b1; cyc(4'd0);
        rst = 1'b1; cyc(4'd1); cyc(4'd2);
        comm_init_detect = 1'b1; cyc(4'd3);
        comm_init_detect = 1'b0; rx_is_elec_idle = 1'b1; cyc(4'd4);
        rx_is_elec_idle = 1'b0; cyc(4'd5);
        comm_wake_detect = 1'b1; cyc(4'd6);
        comm_wake_detect = 1'b0; cyc(4'd7);
    endtask

    task automatic goto_send_align;
        goto_wait_align();
        rx_din = ALIGN; rx_isk = 4'b0001; rx_byte_is_aligned = 1'b1; cyc(4'd8);
    endtask

    task automatic test_reset;
        logic [40:0] e, o;
        rst = 1'b0; platform_ready = 1'b1; cyc(4'd0); cyc(4'd0);
        rst = 1'b1; platform_ready = 1'b0; cyc(4'd0);
        platform_ready = 1'b1; cyc(4'd1);
        rst = 1'b0; cyc(4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_bringup;
        logic [40:0] e, o;
        rst = 1'b0; clear_inputs(); platform_ready = 1'b1; cyc(4'd0);
        rst = 1'b1; cyc(4'd1); cyc(4'd2); cyc(4'd2);
        comm_init_detect = 1'b1; cyc(4'd3); cyc(4'd3);
        comm_init_detect = 1'b0; cyc(4'd3);
        rx_is_elec_idle = 1'b1; cyc(4'd4); cyc(4'd5);
        rx_is_elec_idle = 1'b0; cyc(4'd5);
        comm_wake_detect = 1'b1; cyc(4'd6); cyc(4'd6);
        comm_wake_detect = 1'b0; cyc(4'd7); cyc(4'd7);
        rx_din = ALIGN; rx_isk = 4'b0001; cyc(4'd7);
        rx_byte_is_aligned = 1'b1; cyc(4'd8); cyc(4'd8);
        rx_din = SYNC; cyc(4'd8); cyc(4'd8); cyc(4'd9); cyc(4'd9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bringup: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_no_cominit;
        logic [40:0] e, o;
        rst = 1'b0; clear_inputs(); platform_ready = 1'b1; cyc(4'd0);
        rst = 1'b1; cyc(4'd1);
        repeat (2) begin
            repeat (101) cyc(4'd2);
            cyc(4'd1);
        end
        repeat (101) cyc(4'd2);
        comm_init_detect = 1'b1; cyc(4'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL no_cominit: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_align_timeout;
        logic [40:0] e, o;
        goto_wait_align();
        repeat (100) cyc(4'd7);
        cyc(4'd1); cyc(4'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL align_timeout: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_align_interleave;
        logic [40:0] e, o;
        goto_send_align();
        rx_din = SYNC; cyc(4'd8); cyc(4'd8);
        rx_din = ALIGN; cyc(4'd8);
        rx_din = SYNC; cyc(4'd8);
        rx_isk = 4'b0000; cyc(4'd8);
        rx_isk = 4'b0001; rx_byte_is_aligned = 1'b0; cyc(4'd8);
        rx_byte_is_aligned = 1'b1; cyc(4'd8); cyc(4'd9); cyc(4'd9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL align_interleave: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_ready_cominit;
        logic [40:0] e, o;
        comm_init_detect = 1'b1; cyc(4'd1);
        comm_init_detect = 1'b0; cyc(4'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ready_cominit: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic [40:0] e, o;
        goto_wait_align();
        rst = 1'b0; cyc(4'd0); cyc(4'd0);
        rst = 1'b1; cyc(4'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_platform_drop;
        logic [40:0] e, o;
        goto_send_align();
        rx_din = SYNC; cyc(4'd8);
        platform_ready = 1'b0; cyc(4'd0); cyc(4'd0);
        platform_ready = 1'b1; cyc(4'd1); cyc(4'd2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL platform_drop: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bringup();
        test_no_cominit();
        test_align_timeout();
        test_align_interleave();
        test_ready_cominit();
        test_reset_mid();
        test_platform_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
